// File: rtl/async_pkg.sv
// Shared definitions for the clocked-to-async handshake blocks:
// FSM state encoding and a ceiling-log2 helper for sizing counters.
package async_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return clog2_floor1(result);
    endfunction

    // A one-entry structure still needs a one-bit index.
    function automatic int clog2_floor1(input int bits);
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Bank of independent multi-flop synchronisers, one chain per bit,
// all flops cleared by the asynchronous reset.
module sync_ff #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            logic [STAGES-1:0] pipe_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_reg <= '0;
                end else begin
                    pipe_reg <= {pipe_reg[STAGES-2:0], d[gi]};
                end
            end

            assign q[gi] = pipe_reg[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/sync_fork_tx.sv
// Clocked valid/ready source driving a 4-phase bundled-data request fork
// to OUT_NUM asynchronous consumers, joining their acks before each phase advances.
module sync_fork_tx
    import async_pkg::*;
#(
    parameter int OUT_NUM     = 2,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [OUT_NUM-1:0] in_mask,
    output logic [OUT_NUM-1:0] req,
    output logic [DATA_W-1:0]  data,
    input  logic [OUT_NUM-1:0] ack,
    output logic               done,
    output logic               err,
    input  logic               err_clr
);

    localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] WDOG_ONE = TIMEOUT_W'(1);

    state_t               state_reg, state_next;
    logic [OUT_NUM-1:0]   req_reg, req_next;
    logic [OUT_NUM-1:0]   mask_reg;
    logic [DATA_W-1:0]    data_reg;
    logic                 done_reg, done_next;
    logic                 err_reg, err_next;
    logic                 in_ready_reg, in_ready_next;
    logic [TIMEOUT_W-1:0] wdog_reg, wdog_next;
    logic [SYNC_STAGES-1:0] prime_reg;
    logic                 load;
    logic                 err_set;

    logic [OUT_NUM-1:0]   ack_s;
    logic [OUT_NUM-1:0]   act;
    logic                 primed;

    sync_ff #(
        .W      (OUT_NUM),
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack),
        .q   (ack_s)
    );

    assign act = ack_s & mask_reg;

    // The synchroniser outputs read zero straight out of reset regardless of
    // the real ack levels, so accept stays blocked until the chain has refilled.
    assign primed = prime_reg[SYNC_STAGES-1];

    assign in_ready = in_ready_reg && (ack_s == '0) && (state_reg == ST_IDLE);

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        done_next  = 1'b0;
        load       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    load = 1'b1;
                    if (in_mask != '0) begin
                        req_next   = in_mask;
                        state_next = ST_RISE;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ST_RISE: begin
                if (act == mask_reg) begin
                    req_next   = '0;
                    state_next = ST_FALL;
                end
            end
            ST_FALL: begin
                if (act == '0) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                req_next   = '0;
                state_next = ST_IDLE;
            end
        endcase

        in_ready_next = primed && (state_next == ST_IDLE) && (ack_s == '0);
    end

    // Watchdog restarts on every phase change and only runs while a phase is pending.
    always_comb begin
        wdog_next = wdog_reg;
        err_set   = 1'b0;
        if (state_next != state_reg) begin
            wdog_next = '0;
        end else if ((state_reg != ST_IDLE) && (wdog_reg != WDOG_MAX)) begin
            wdog_next = wdog_reg + WDOG_ONE;
            err_set   = (wdog_next == WDOG_MAX);
        end

        err_next = err_reg;
        if (err_set) begin
            err_next = 1'b1;
        end else if (err_clr) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            req_reg      <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            in_ready_reg <= 1'b0;
            wdog_reg     <= '0;
            prime_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            req_reg      <= req_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            in_ready_reg <= in_ready_next;
            wdog_reg     <= wdog_next;
            prime_reg    <= {prime_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Payload and branch set only change on accept, so data stays bundled
    // with req for the whole rise and fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_reg <= '0;
            data_reg <= '0;
        end else if (load) begin
            mask_reg <= in_mask;
            data_reg <= in_data;
        end
    end

    assign req  = req_reg;
    assign data = data_reg;
    assign done = done_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_sync_fork_tx.sv
// Scoreboard bench for sync_fork_tx: behavioural delayed-echo consumers per branch,
// expected tokens queued at accept and checked at each done pulse.
module tb_sync_fork_tx;

    localparam int OUT_NUM     = 2;
    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_W   = 4;

    typedef struct {
        logic [DATA_W-1:0]  d;
        logic [OUT_NUM-1:0] m;
    } token_t;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [OUT_NUM-1:0] in_mask;
    logic [OUT_NUM-1:0] req;
    logic [DATA_W-1:0]  data;
    logic [OUT_NUM-1:0] ack;
    logic               done;
    logic               err;
    logic               err_clr;

    logic [OUT_NUM-1:0] cons_auto;
    logic [OUT_NUM-1:0] man_val;
    int                 cons_dly [OUT_NUM];

    token_t             sb_q [$];
    logic [OUT_NUM-1:0] req_seen;
    logic               data_bad;
    int                 n_txn;
    int                 n_chk;
    int                 n_pass;

    sync_fork_tx #(
        .OUT_NUM     (OUT_NUM),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_W   (TIMEOUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mask  (in_mask),
        .req      (req),
        .data     (data),
        .ack      (ack),
        .done     (done),
        .err      (err),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each consumer echoes its req after cons_dly negedges, or follows man_val.
    generate
        for (genvar gi = 0; gi < OUT_NUM; gi++) begin : g_cons
            logic a;
            int   cnt;
            assign ack[gi] = cons_auto[gi] ? a : man_val[gi];
            initial begin
                a   = 1'b0;
                cnt = 0;
                forever begin
                    @(negedge clk);
                    if (cons_auto[gi] && (a != req[gi])) begin
                        cnt = cnt + 1;
                        if (cnt >= cons_dly[gi]) begin
                            a   = req[gi];
                            cnt = 0;
                        end
                    end else begin
                        cnt = 0;
                    end
                end
            end
        end
    endgenerate

    always @(negedge clk) begin
        if (rst) begin
            req_seen = '0;
            data_bad = 1'b0;
        end else begin
            req_seen = req_seen | req;
            if ((req != '0) && (sb_q.size() > 0) && (data != sb_q[0].d)) data_bad = 1'b1;
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_done", 32'(sb_q.size()), 1);
                end else begin
                    token_t t;
                    t = sb_q.pop_front();
                    n_txn = n_txn + 1;
                    $display("txn %0d: data=%h mask=%b req_seen=%b", n_txn, data, t.m, req_seen);
                    check("sb_data", 32'(data), 32'(t.d));
                    check("sb_req_mask", 32'(req_seen), 32'(t.m));
                    check("sb_data_stable", 32'(data_bad), 0);
                end
                req_seen = '0;
                data_bad = 1'b0;
            end
        end
    end

    task automatic send(input logic [DATA_W-1:0] d, input logic [OUT_NUM-1:0] m);
        token_t t;
        int     i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (i == 200) check("send_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = m;
        t.d = d;
        t.m = m;
        @(posedge clk);
        sb_q.push_back(t);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (i == 200) check(tag, 0, 1);
    endtask

    task automatic wait_req(input string tag, input logic [OUT_NUM-1:0] v);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req == v) break;
        end
        if (i == 200) check(tag, 32'(req), 32'(v));
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int k;
        n_chk     = 0;
        n_pass    = 0;
        n_txn     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mask   = '0;
        err_clr   = 1'b0;
        cons_auto = '1;
        man_val   = '0;
        for (int i = 0; i < OUT_NUM; i++) cons_dly[i] = 3;

        repeat (3) @(negedge clk);
        check("rst_req", 32'(req), 0);
        check("rst_data", 32'(data), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("ready_after_rst", 32'(in_ready), 1);

        // Both branches echo after 3 cycles.
        send(8'hA5, 2'b11);
        @(negedge clk);
        check("t1_req_up", 32'(req), 32'(2'b11));
        check("t1_ready_busy", 32'(in_ready), 0);
        wait_done("t1_done_timeout");
        check("t1_req_down", 32'(req), 0);
        check("t1_ready_back", 32'(in_ready), 1);
        @(negedge clk);
        check("t1_done_width", 32'(done), 0);

        // Skewed acks: the rise must wait for the slow branch.
        cons_dly[0] = 2;
        cons_dly[1] = 20;
        send(8'h3C, 2'b11);
        repeat (15) @(negedge clk);
        check("t2_req_held", 32'(req), 32'(2'b11));
        wait_done("t2_done_timeout");
        check("t2_acks_low_at_done", 32'(ack), 0);
        check("t2_wdog_err", 32'(err), 1);
        cons_dly[1] = 3;

        // Only branch 1 enabled, branch 0 silent.
        cons_auto = 2'b10;
        man_val   = 2'b00;
        send(8'h5A, 2'b10);
        @(negedge clk);
        check("t3_req_one", 32'(req), 32'(2'b10));
        wait_done("t3_done_timeout");

        // Empty mask completes without touching req.
        cons_auto = 2'b11;
        send(8'hC3, 2'b00);
        @(negedge clk);
        check("t4_done_next", 32'(done), 1);
        check("t4_req_zero", 32'(req), 0);
        @(negedge clk);
        check("t4_done_width", 32'(done), 0);

        // Watchdog: no acks for 15 RISE cycles.
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t5_err_cleared_pre", 32'(err), 0);
        cons_auto = 2'b00;
        man_val   = 2'b00;
        send(8'h96, 2'b11);
        repeat (15) @(negedge clk);
        check("t5_err_before", 32'(err), 0);
        @(negedge clk);
        check("t5_err_set", 32'(err), 1);
        check("t5_req_held", 32'(req), 32'(2'b11));
        for (int i = 0; i < OUT_NUM; i++) cons_dly[i] = 2;
        cons_auto = 2'b11;
        wait_done("t5_done_timeout");
        check("t5_err_sticky", 32'(err), 1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t5_err_clr", 32'(err), 0);

        // Reset while in FALL with acks held high.
        cons_auto = 2'b00;
        man_val   = 2'b00;
        send(8'h77, 2'b11);
        wait_req("t6_req_up_timeout", 2'b11);
        man_val = 2'b11;
        wait_req("t6_req_down_timeout", 2'b00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_req", 32'(req), 0);
        check("t6_rst_ready", 32'(in_ready), 0);
        check("t6_rst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        repeat (10) @(negedge clk);
        check("t6_ready_blocked", 32'(in_ready), 0);
        man_val = 2'b00;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("t6_ready_latency", 32'(k + 1), 32'(SYNC_STAGES + 1));
        check("t6_sb_empty", 32'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
